load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data-memory port: accepts one load/store request at a time from the CPU execute stage.
- Drives the mem port signals (address, data_in, read_write, access_size, unsigned_access) and samples data_out.
- Returns a load result or a fault to writeback with a valid/ready handshake.
- Optionally splits misaligned accesses into byte sequences.

Parameters:
- ADDR_W, 32, address width; mem_address is zero-extended to 32 bits if smaller.
- RESET_PC_SAFE, 1, when 1, mem_read_write is forced to read whenever reset is high.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept; high only in IDLE
- req_store  in  1  1=store, 0=load
- req_funct3  in  3  RV32 funct3 (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101)
- req_address  in  32  byte address
- req_store_data  in  32  store data, LSB-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  writeback accepts response
- resp_data  out  32  load result, extended; 0 for stores and faults
- resp_fault  out  1  misaligned or illegal funct3
- mem_address  out  32  to mem address
- mem_data_in  out  32  to mem data_in
- mem_data_out  in  32  from mem data_out (combinational read)
- mem_read_write  out  1  1=read, 0=write; mem writes on every edge while 0
- mem_access_size  out  2  00 byte, 01 half, 10 word
- mem_unsigned_access  out  1  to mem unsigned_access

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset: state=IDLE, resp_valid=0, resp_data=0, resp_fault=0, mem_read_write=1, mem_address=0, mem_data_in=0, mem_access_size=00, mem_unsigned_access=0.
- Reset mid-operation: abandons the request with no response. While reset is high, mem_read_write=1 combinationally, so no store collides with mem setup writes.
- IDLE: req_ready=1.
  - On req_valid, register the request; next state ACCESS.
  - If funct3 is illegal (load 011/110/111; store with funct3[2]=1 or 011): next state RESP with fault=1 and no mem access.
- Misalignment check (feature off): half with addr[0]=1, or word with addr[1:0]!=0.
  - Result: fault=1, RESP, no mem access.
- ACCESS: mem outputs driven from registered request for exactly one cycle.
  - Store: mem_read_write=0 only in this cycle.
  - Load: mem_data_out captured at the end of the cycle into resp_data. mem already sign/zero-extends per access_size and unsigned_access = funct3[2].
  - Next state RESP.
- RESP: resp_valid=1; resp_data and resp_fault hold stable until resp_ready.
  - On resp_valid && resp_ready, next state IDLE. A new request is taken the following cycle.
- Latency: accept at cycle N, ACCESS at N+1, resp_valid at N+2. Throughput is one request per 3 cycles with resp_ready tied high.
- Outside ACCESS: mem_read_write=1; other mem outputs hold their last values.
- Address arithmetic is modulo 2^32. Wrap at 0xFFFFFFFF is not a fault for byte access.

Optional Feature:
- Macro: MISALIGNED_SPLIT_EN.
- Defined: a misaligned half/word does not fault. ACCESS repeats n times (n=2 half, 4 word) with a 2-bit byte counter.
  - Each step issues a byte access at addr+k with mem_unsigned_access=1.
  - Store: byte k = store_data[8k+7:8k]. Load: assembles mem_data_out[7:0] into byte k.
  - After the last byte, the LSU sign- or zero-extends per funct3, then goes to RESP.
  - Latency is n+1 cycles to resp_valid. Aligned accesses are unchanged.
- Undefined: misaligned accesses fault as described above; the byte counter logic is absent.

Decomposition:
- Package lsu_pkg:
  - ACCESS_SIZE_BYTE/HALF/WORD/RSVD constants.
  - FUNCT3_* constants.
  - lsu_state_t enum (IDLE, ACCESS, RESP).
  - Helper function is_misaligned(size, addr).
- Sub-module lsu_load_extend: combinational byte assembly plus sign/zero extension. Used only under MISALIGNED_SPLIT_EN but always compiled for reuse.

Test Plan:
- Preload 0x100=0x8899AABB via mem setup; LW 0x100 -> resp_valid at N+2, resp_data=0x8899AABB, fault=0.
- LB 0x101 -> 0xFFFFFFAA; LBU 0x101 -> 0x000000AA; LH 0x102 -> 0xFFFF8899; LHU 0x102 -> 0x00008899.
- SH 0x200 data 0x12345678, then LW 0x200 over zeroed memory -> 0x00005678. mem_read_write low exactly one cycle.
- LW 0x103 without macro -> fault=1, data=0, mem_read_write never low. With macro -> 4 byte accesses at 0x103..0x106, correct assembled word, resp_valid at N+5.
- Hold resp_ready=0 for 5 cycles -> resp_valid and resp_data stable, req_ready=0. Assert reset during ACCESS of a store -> no write, state IDLE, resp_valid=0 next cycle.
- funct3=011 load -> fault=1 with no mem access.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types, encodings and helpers for the load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] ACCESS_SIZE_BYTE = 2'b00;
    localparam logic [1:0] ACCESS_SIZE_HALF = 2'b01;
    localparam logic [1:0] ACCESS_SIZE_WORD = 2'b10;
    localparam logic [1:0] ACCESS_SIZE_RSVD = 2'b11;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    typedef struct packed {
        logic            store;
        logic [2:0]      funct3;
        logic [XLEN-1:0] address;
        logic [XLEN-1:0] store_data;
    } lsu_req_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            ACCESS_SIZE_HALF: return addr_lo[0];
            ACCESS_SIZE_WORD: return addr_lo != 2'b00;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic is_legal(input logic store, input logic [2:0] funct3);
        if (store) begin
            return (funct3 == FUNCT3_SB) || (funct3 == FUNCT3_SH) || (funct3 == FUNCT3_SW);
        end
        return (funct3 == FUNCT3_LB) || (funct3 == FUNCT3_LH) || (funct3 == FUNCT3_LW) ||
               (funct3 == FUNCT3_LBU) || (funct3 == FUNCT3_LHU);
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Merges one byte into a partially assembled load word and sign/zero-extends
// the result according to funct3.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] partial_i,
    input  logic [7:0]      byte_i,
    input  logic [1:0]      idx_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] merged_c,
    output logic [XLEN-1:0] extended_c
);

    always_comb begin
        merged_c = partial_i;
        case (idx_i)
            2'd0:    merged_c[7:0]   = byte_i;
            2'd1:    merged_c[15:8]  = byte_i;
            2'd2:    merged_c[23:16] = byte_i;
            default: merged_c[31:24] = byte_i;
        endcase
    end

    always_comb begin
        case (funct3_i[1:0])
            ACCESS_SIZE_BYTE: extended_c = {{24{~funct3_i[2] & merged_c[7]}}, merged_c[7:0]};
            ACCESS_SIZE_HALF: extended_c = {{16{~funct3_i[2] & merged_c[15]}}, merged_c[15:0]};
            default:          extended_c = merged_c;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, response via valid/ready.
// Build option MISALIGNED_SPLIT_EN splits misaligned half/word into byte accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W        = 32,
    parameter bit          RESET_PC_SAFE = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_store_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        mem_read_write,
    output logic [1:0]  mem_access_size,
    output logic        mem_unsigned_access
);

    lsu_state_t  state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_fault_q, resp_fault_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_data_in_q, mem_data_in_d;
    logic        mem_rw_q, mem_rw_d;
    logic [1:0]  mem_size_q, mem_size_d;
    logic        mem_unsigned_q, mem_unsigned_d;

    logic [31:0] req_addr_ext;
    logic        legal_c;
    logic        misaligned_c;

    assign req_addr_ext = 32'(req_address[ADDR_W-1:0]);
    assign legal_c      = is_legal(req_store, req_funct3);
    assign misaligned_c = is_misaligned(req_funct3[1:0], req_address[1:0]);

`ifdef MISALIGNED_SPLIT_EN
    lsu_req_t    req_q, req_d;
    logic        split_q, split_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  cnt_nxt;
    logic [1:0]  cnt_last;
    logic [31:0] buf_q, buf_d;
    logic [31:0] split_addr;
    logic [31:0] merged_c;
    logic [31:0] extended_c;

    assign cnt_nxt    = cnt_q + 2'd1;
    assign cnt_last   = (req_q.funct3[1:0] == ACCESS_SIZE_HALF) ? 2'd1 : 2'd3;
    assign split_addr = 32'(req_q.address[ADDR_W-1:0] + ADDR_W'(cnt_nxt));

    lsu_load_extend u_load_extend (
        .partial_i  (buf_q),
        .byte_i     (mem_data_out[7:0]),
        .idx_i      (cnt_q),
        .funct3_i   (req_q.funct3),
        .merged_c   (merged_c),
        .extended_c (extended_c)
    );
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        resp_data_d    = resp_data_q;
        resp_fault_d   = resp_fault_q;
        mem_address_d  = mem_address_q;
        mem_data_in_d  = mem_data_in_q;
        mem_rw_d       = 1'b1;
        mem_size_d     = mem_size_q;
        mem_unsigned_d = mem_unsigned_q;
`ifdef MISALIGNED_SPLIT_EN
        req_d   = req_q;
        split_d = split_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    resp_data_d  = '0;
                    resp_fault_d = 1'b0;
                    if (!legal_c) begin
                        state_d      = RESP;
                        resp_fault_d = 1'b1;
`ifdef MISALIGNED_SPLIT_EN
                    end else if (misaligned_c) begin
                        state_d        = ACCESS;
                        split_d        = 1'b1;
                        cnt_d          = 2'd0;
                        buf_d          = '0;
                        req_d          = '{store: req_store, funct3: req_funct3,
                                           address: req_address, store_data: req_store_data};
                        mem_address_d  = req_addr_ext;
                        mem_data_in_d  = {24'd0, req_store_data[7:0]};
                        mem_size_d     = ACCESS_SIZE_BYTE;
                        mem_unsigned_d = 1'b1;
                        mem_rw_d       = ~req_store;
`else
                    end else if (misaligned_c) begin
                        state_d      = RESP;
                        resp_fault_d = 1'b1;
`endif
                    end else begin
                        state_d        = ACCESS;
                        mem_address_d  = req_addr_ext;
                        mem_data_in_d  = req_store_data;
                        mem_size_d     = req_funct3[1:0];
                        mem_unsigned_d = req_funct3[2];
                        mem_rw_d       = ~req_store;
`ifdef MISALIGNED_SPLIT_EN
                        split_d        = 1'b0;
`endif
                    end
                end
            end
            ACCESS: begin
                state_d     = RESP;
                resp_data_d = mem_rw_q ? mem_data_out : '0;
`ifdef MISALIGNED_SPLIT_EN
                // Byte-wise sequence: collect load bytes, step address until last byte.
                if (split_q) begin
                    resp_data_d = '0;
                    if (!req_q.store) begin
                        buf_d = merged_c;
                    end
                    if (cnt_q != cnt_last) begin
                        state_d       = ACCESS;
                        cnt_d         = cnt_nxt;
                        mem_address_d = split_addr;
                        mem_data_in_d = {24'd0, 8'(req_q.store_data >> {cnt_nxt, 3'b000})};
                        mem_rw_d      = ~req_q.store;
                    end else if (!req_q.store) begin
                        resp_data_d = extended_c;
                    end
                end
`endif
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        resp_valid_d = (state_d == RESP);
        req_ready_d  = (state_d == IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            resp_fault_q   <= 1'b0;
            mem_address_q  <= '0;
            mem_data_in_q  <= '0;
            mem_rw_q       <= 1'b1;
            mem_size_q     <= ACCESS_SIZE_BYTE;
            mem_unsigned_q <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
            req_q          <= '0;
            split_q        <= 1'b0;
            cnt_q          <= 2'd0;
            buf_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_data_q    <= resp_data_d;
            resp_fault_q   <= resp_fault_d;
            mem_address_q  <= mem_address_d;
            mem_data_in_q  <= mem_data_in_d;
            mem_rw_q       <= mem_rw_d;
            mem_size_q     <= mem_size_d;
            mem_unsigned_q <= mem_unsigned_d;
`ifdef MISALIGNED_SPLIT_EN
            req_q          <= req_d;
            split_q        <= split_d;
            cnt_q          <= cnt_d;
            buf_q          <= buf_d;
`endif
        end
    end

    // Reset overrides the write strobe immediately so setup writes are never disturbed.
    assign mem_read_write      = (RESET_PC_SAFE && reset) ? 1'b1 : mem_rw_q;
    assign req_ready           = req_ready_q;
    assign resp_valid          = resp_valid_q;
    assign resp_data           = resp_data_q;
    assign resp_fault          = resp_fault_q;
    assign mem_address         = mem_address_q;
    assign mem_data_in         = mem_data_in_q;
    assign mem_access_size     = mem_size_q;
    assign mem_unsigned_access = mem_unsigned_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory device, behavioural reference
// model, directed and randomized requests (MISALIGNED_SPLIT_EN aware).
module tb_load_store_unit;

`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_address = '0;
    logic [31:0] req_store_data = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out = '0;
    logic        mem_read_write;
    logic [1:0]  mem_access_size;
    logic        mem_unsigned_access;

    always #5 clock = ~clock;

    load_store_unit #(.ADDR_W(32), .RESET_PC_SAFE(1'b1)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_address(req_address), .req_store_data(req_store_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_fault(resp_fault), .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_read_write(mem_read_write),
        .mem_access_size(mem_access_size), .mem_unsigned_access(mem_unsigned_access)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory device (DUT side) ----------------
    logic [7:0]  dev_mem [bit [31:0]];
    int          dev_gen = 0;
    int          wr_cycles = 0;
    logic [31:0] wr_addr_q [$];

    function automatic logic [7:0] dev_rd8(input logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] v, input int n, input logic uns);
        if (n == 1) return uns ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
        if (n == 2) return uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    always @(mem_address or mem_access_size or mem_unsigned_access or dev_gen) begin
        logic [31:0] v;
        int n;
        n = (mem_access_size == 2'b00) ? 1 : (mem_access_size == 2'b01) ? 2 : 4;
        v = '0;
        for (int k = 0; k < n; k++) v = v | (32'(dev_rd8(mem_address + 32'(k))) << (8 * k));
        mem_data_out = extend(v, n, mem_unsigned_access);
    end

    always @(posedge clock) begin
        if (mem_read_write == 1'b0) begin
            int n;
            n = (mem_access_size == 2'b00) ? 1 : (mem_access_size == 2'b01) ? 2 : 4;
            for (int k = 0; k < n; k++) dev_mem[mem_address + 32'(k)] = 8'(mem_data_in >> (8 * k));
            wr_cycles++;
            wr_addr_q.push_back(mem_address);
            dev_gen++;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [bit [31:0]];

    function automatic logic [7:0] ref_rd8(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         output logic fault, output logic [31:0] data, output int lat, output int nwr);
        logic legal, mis;
        int n;
        logic [31:0] v;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis   = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
        fault = !legal || (mis && !SPLIT);
        v = '0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_rd8(a + 32'(k))) << (8 * k));
        data = (fault || st) ? 32'd0 : extend(v, n, f3[2]);
        lat  = fault ? 0 : (mis ? n : 1);
        nwr  = (st && !fault) ? (mis ? n : 1) : 0;
    endtask

    // ---------------- per-cycle compare ----------------
    logic        mon_en = 1'b0;
    logic        busy = 1'b0;
    logic [31:0] exp_data = '0;
    logic        exp_fault = 1'b0;

    always @(negedge clock) begin
        if (mon_en && !reset) begin
            if (!busy) begin
                chk("idle_req_ready", 32'(req_ready), 32'd1);
                chk("idle_resp_valid", 32'(resp_valid), 32'd0);
            end else if (resp_valid) begin
                chk("resp_data", resp_data, exp_data);
                chk("resp_fault", 32'(resp_fault), 32'(exp_fault));
                chk("resp_req_ready", 32'(req_ready), 32'd0);
            end
        end
    end

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input int hold,
                          output logic [31:0] got, output logic got_fault);
        logic ef;
        logic [31:0] ed;
        int el, ew, w0, lat;
        model(st, f3, a, ef, ed, el, ew);
        @(negedge clock);
        exp_data = ed; exp_fault = ef;
        wr_addr_q.delete();
        w0 = wr_cycles;
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_address = a; req_store_data = d;
        resp_ready = (hold == 0);
        @(posedge clock);
        busy = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        req_store_data = $urandom;
        lat = 0;
        while (!resp_valid && lat < 16) begin
            @(negedge clock);
            lat++;
        end
        chk("latency", 32'(lat), 32'(el));
        got = resp_data; got_fault = resp_fault;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk("hold_valid", 32'(resp_valid), 32'd1);
        end
        resp_ready = 1'b1;
        @(posedge clock);
        busy = 1'b0;
        chk("write_cycles", 32'(wr_cycles - w0), 32'(ew));
        for (int k = 0; k < ew && k < wr_addr_q.size(); k++)
            chk("write_addr", wr_addr_q[k], a + ((ew > 1) ? 32'(k) : 32'd0));
        if (st && !ef) begin
            for (int k = 0; k < ((f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4); k++)
                ref_mem[a + 32'(k)] = 8'(d >> (8 * k));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        logic        gf;
        logic [2:0]  legal_loads [5];
        legal_loads[0] = 3'b000; legal_loads[1] = 3'b001; legal_loads[2] = 3'b010;
        legal_loads[3] = 3'b100; legal_loads[4] = 3'b101;

        // Setup writes: 0x100 = 0x8899AABB, little-endian
        for (int k = 0; k < 4; k++) begin
            dev_mem[32'h100 + 32'(k)] = 8'(32'h8899AABB >> (8 * k));
            ref_mem[32'h100 + 32'(k)] = 8'(32'h8899AABB >> (8 * k));
        end
        dev_gen++;

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_mem_rw", 32'(mem_read_write), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_fault", 32'(resp_fault), 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_data_in", mem_data_in, 32'd0);
        chk("rst_mem_size", 32'(mem_access_size), 32'd0);
        chk("rst_mem_unsigned", 32'(mem_unsigned_access), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        reset = 1'b0;
        mon_en = 1'b1;

        do_req(1'b0, 3'b010, 32'h100, 0, 0, got, gf);  chk("pin_lw", got, 32'h8899AABB);
        do_req(1'b0, 3'b000, 32'h101, 0, 0, got, gf);  chk("pin_lb", got, 32'hFFFFFFAA);
        do_req(1'b0, 3'b100, 32'h101, 0, 0, got, gf);  chk("pin_lbu", got, 32'h000000AA);
        do_req(1'b0, 3'b001, 32'h102, 0, 0, got, gf);  chk("pin_lh", got, 32'hFFFF8899);
        do_req(1'b0, 3'b101, 32'h102, 0, 0, got, gf);  chk("pin_lhu", got, 32'h00008899);
        do_req(1'b1, 3'b001, 32'h200, 32'h12345678, 0, got, gf);
        do_req(1'b0, 3'b010, 32'h200, 0, 0, got, gf);  chk("pin_sh_lw", got, 32'h00005678);
        do_req(1'b0, 3'b010, 32'h103, 0, 0, got, gf);
`ifdef MISALIGNED_SPLIT_EN
        chk("pin_mis_lw", got, 32'h00000088);
        chk("pin_mis_fault", 32'(gf), 32'd0);
`else
        chk("pin_mis_lw", got, 32'h00000000);
        chk("pin_mis_fault", 32'(gf), 32'd1);
`endif
        do_req(1'b0, 3'b010, 32'h100, 0, 5, got, gf);  chk("pin_hold", got, 32'h8899AABB);
        do_req(1'b0, 3'b011, 32'h100, 0, 0, got, gf);  chk("pin_illegal", 32'(gf), 32'd1);
        do_req(1'b0, 3'b000, 32'hFFFFFFFF, 0, 0, got, gf); chk("pin_wrap_byte", 32'(gf), 32'd0);

        // Reset during the write cycle of a store: nothing may reach memory.
        mon_en = 1'b0;
        @(negedge clock);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
        req_address = 32'h400; req_store_data = 32'hDEADBEEF;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        chk("abort_in_access", 32'(mem_read_write), 32'd0);
        begin
            int w0;
            w0 = wr_cycles;
            reset = 1'b1;
            #1 chk("abort_rw_forced", 32'(mem_read_write), 32'd1);
            @(posedge clock);
            @(negedge clock);
            chk("abort_no_write", 32'(wr_cycles - w0), 32'd0);
            chk("abort_resp_valid", 32'(resp_valid), 32'd0);
            chk("abort_req_ready", 32'(req_ready), 32'd1);
            chk("abort_mem_address", mem_address, 32'd0);
        end
        reset = 1'b0;
        mon_en = 1'b1;
        do_req(1'b0, 3'b010, 32'h400, 0, 0, got, gf);  chk("pin_abort_lw", got, 32'h00000000);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 120; i++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] a;
            int          hold;
            st = 1'($urandom % 2);
            if ($urandom % 8 == 0) f3 = 3'($urandom % 8);
            else if (st) f3 = 3'($urandom % 3);
            else f3 = legal_loads[$urandom % 5];
            if ($urandom % 5 == 0) a = 32'hFFFFFFF8 + 32'($urandom % 8);
            else a = 32'h300 + 32'($urandom % 64);
            hold = ($urandom % 4 == 0) ? int'($urandom % 3) : 0;
            do_req(st, f3, a, $urandom, hold, got, gf);
        end

        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
